// File: rtl/ride_metrics_pkg.sv
// Shared widths, limits and helpers for the ride figures and the display control block.
package ride_metrics_pkg;

    // Output figure widths and limits, shared with the display control block.
    localparam int SPEED_W   = 7;
    localparam int DIST_W    = 14;
    localparam int AVG_W     = 10;
    localparam int SPEED_MAX = 99;
    localparam int DIST_MAX  = 9999;
    localparam int AVG_MAX   = 999;

    // Internal accumulator widths.
    localparam int WIN_MM_W   = 16;  // millimetres in the current speed window
    localparam int MM_W       = 16;  // millimetres not yet folded into metres
    localparam int METERS_W   = 20;  // trip metres
    localparam int HM_W       = 7;   // metres toward the next 0.1 km
    localparam int MOV_HS_W   = 20;  // half-seconds spent moving
    localparam int DIVIDEND_W = 27;  // metres * 72

    // Average-speed divider sequencing.
    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    // Q16 factor turning millimetres per window into km/h, rounded to nearest.
    function automatic int speed_mul(input int win_halfsecs);
        return (235929600 + win_halfsecs * 250000) / (win_halfsecs * 500000);
    endfunction

endpackage

// File: rtl/ride_metrics_if.sv
// Ride input strobes and the four ride figures handed to the display control block.
interface ride_metrics_if;
    import ride_metrics_pkg::*;

    logic                half_sec_pulse;
    logic                wheel_raw;
    logic                clear_trip;
    logic [SPEED_W-1:0]  speed;
    logic [SPEED_W-1:0]  max_speed;
    logic [DIST_W-1:0]   distance;
    logic [AVG_W-1:0]    avg_speed;

    modport master (
        output half_sec_pulse, wheel_raw, clear_trip,
        input  speed, max_speed, distance, avg_speed
    );

    modport slave (
        input  half_sec_pulse, wheel_raw, clear_trip,
        output speed, max_speed, distance, avg_speed
    );

endinterface

// File: rtl/ride_metrics_seq_divider.sv
// Restoring divider, one quotient bit per clock; abort drops the divide without a done.
module seq_divider
    import ride_metrics_pkg::*;
#(
    parameter int N_W = 27,
    parameter int D_W = 20
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);
    localparam int CNT_W = $clog2(N_W);

    div_state_e       state;
    logic [N_W-1:0]   q_sh;
    logic [D_W-1:0]   rem;
    logic [D_W-1:0]   dsr;
    logic [CNT_W-1:0] cnt;
    logic [D_W:0]     trial;
    logic             fits;
    logic [N_W-1:0]   q_next;

    // The remainder is always below the divisor, so one extra bit holds the trial value.
    assign trial  = {rem, q_sh[N_W-1]};
    assign fits   = (trial >= {1'b0, dsr});
    assign q_next = {q_sh[N_W-2:0], fits};

    // Load on start, then shift-subtract N_W times; done pulses with the final quotient.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= DIV_IDLE;
            q_sh     <= '0;
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= DIV_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start) begin
                            q_sh  <= dividend;
                            dsr   <= divisor;
                            rem   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= DIV_RUN;
                        end
                    end
                    DIV_RUN: begin
                        rem  <= fits ? D_W'(trial - {1'b0, dsr}) : D_W'(trial);
                        q_sh <= q_next;
                        if (cnt == CNT_W'(N_W - 1)) begin
                            state    <= DIV_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            quotient <= q_next;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ride_metrics.sv
// Reed-switch front end: window speed, peak speed, trip distance and trip average speed.
module ride_metrics
    import ride_metrics_pkg::*;
#(
    parameter int CIRC_MM         = 2100,
    parameter int WINDOW_HALFSECS = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input logic           clock,
    input logic           reset,
    ride_metrics_if.slave bus
);
    localparam int SPEED_MUL = speed_mul(WINDOW_HALFSECS);
    localparam int LOCK_W    = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int WCNT_W    = $clog2(WINDOW_HALFSECS + 2);
    localparam int WSUM_W    = WIN_MM_W + 1;

    logic tick;
    logic clear;
    assign tick  = bus.half_sec_pulse;
    assign clear = bus.clear_trip;

    // ---------------- edge detect and debounce ----------------
    logic              sync1, sync2, prev;
    logic [LOCK_W-1:0] lock_cnt;
    logic              pulse;

    assign pulse = sync2 && !prev && (lock_cnt == '0);

    // Synchronise the switch, take rising edges, and ignore bounces for a lockout period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            sync1 <= bus.wheel_raw;
            sync2 <= sync1;
            prev  <= sync2;
            if (pulse)                lock_cnt <= LOCK_W'(DEBOUNCE_CYCLES);
            else if (lock_cnt != '0)  lock_cnt <= lock_cnt - LOCK_W'(1);
        end
    end

    // ---------------- speed window ----------------
    logic [WIN_MM_W-1:0] win_mm;
    logic [WSUM_W-1:0]   win_sum;
    logic [WCNT_W-1:0]   win_cnt;
    logic                win_end;
    logic [31:0]         speed_prod;
    logic [15:0]         speed_kmh;
    logic [SPEED_W-1:0]  new_speed;

    assign win_sum    = {1'b0, win_mm} + WSUM_W'(CIRC_MM);
    assign win_end    = (win_cnt == WCNT_W'(WINDOW_HALFSECS));
    assign speed_prod = 32'(win_mm) * 32'(SPEED_MUL);
    assign speed_kmh  = 16'(speed_prod >> 16);
    assign new_speed  = (speed_kmh > 16'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX) : speed_kmh[SPEED_W-1:0];

    // Accumulate distance and ticks for the window; a pulse on the closing clock opens the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_mm  <= '0;
            win_cnt <= '0;
        end else if (win_end) begin
            win_mm  <= pulse ? WIN_MM_W'(CIRC_MM) : '0;
            win_cnt <= tick ? WCNT_W'(1) : '0;
        end else begin
            if (pulse) win_mm  <= win_sum[WIN_MM_W] ? '1 : win_sum[WIN_MM_W-1:0];
            if (tick)  win_cnt <= win_cnt + WCNT_W'(1);
        end
    end

    // ---------------- distance chain ----------------
    logic [MM_W-1:0]     mm_acc;
    logic [METERS_W-1:0] meters;
    logic [HM_W-1:0]     hm_cnt;
    logic [DIST_W-1:0]   distance;
    logic                carry;

    assign carry = (mm_acc >= MM_W'(1000));

    // Fold revolutions into millimetres and drain one metre per clock toward 0.1 km steps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mm_acc   <= '0;
            meters   <= '0;
            hm_cnt   <= '0;
            distance <= '0;
        end else if (clear) begin
            mm_acc   <= '0;
            meters   <= '0;
            hm_cnt   <= '0;
            distance <= '0;
        end else begin
            mm_acc <= mm_acc + (pulse ? MM_W'(CIRC_MM) : '0) - (carry ? MM_W'(1000) : '0);
            if (carry) begin
                if (meters != '1) meters <= meters + METERS_W'(1);
                if (hm_cnt == HM_W'(99)) begin
                    hm_cnt <= '0;
                    if (distance != DIST_W'(DIST_MAX)) distance <= distance + DIST_W'(1);
                end else begin
                    hm_cnt <= hm_cnt + HM_W'(1);
                end
            end
        end
    end

    // ---------------- moving time ----------------
    logic                moved;
    logic [MOV_HS_W-1:0] mov_hs;

    // Count half-seconds in which the wheel turned; a pulse on the tick belongs to the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            moved  <= 1'b0;
            mov_hs <= '0;
        end else begin
            if (tick)       moved <= pulse;
            else if (pulse) moved <= 1'b1;
            if (clear)                                 mov_hs <= '0;
            else if (tick && moved && mov_hs != '1)    mov_hs <= mov_hs + MOV_HS_W'(1);
        end
    end

    // ---------------- average speed divider ----------------
    logic                  div_start, div_busy, div_done;
    logic [DIVIDEND_W-1:0] dividend, quotient;

    // 0.1 km/h = metres * 3.6 * 10 / (half-seconds / 2) = metres * 72 / half-seconds.
    assign dividend  = DIVIDEND_W'(meters) * DIVIDEND_W'(72);
    assign div_start = win_end && !clear && !div_busy && (mov_hs != '0);

    seq_divider #(
        .N_W (DIVIDEND_W),
        .D_W (MOV_HS_W)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .abort    (clear),
        .dividend (dividend),
        .divisor  (mov_hs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    // ---------------- published figures ----------------
    logic [SPEED_W-1:0] speed, max_speed;
    logic [AVG_W-1:0]   avg_speed;

    // Publish window speed, track the peak, and write back the average when the divide lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            speed     <= '0;
            max_speed <= '0;
            avg_speed <= '0;
        end else begin
            if (win_end) speed <= new_speed;
            if (clear) begin
                max_speed <= '0;
                avg_speed <= '0;
            end else begin
                if (win_end && new_speed > max_speed) max_speed <= new_speed;
                if (win_end && mov_hs == '0)
                    avg_speed <= '0;
                else if (div_done)
                    avg_speed <= (quotient > DIVIDEND_W'(AVG_MAX)) ? AVG_W'(AVG_MAX) : quotient[AVG_W-1:0];
            end
        end
    end

    assign bus.speed     = speed;
    assign bus.max_speed = max_speed;
    assign bus.distance  = distance;
    assign bus.avg_speed = avg_speed;

endmodule

// File: tb/tb_ride_metrics.sv
// Directed bench for ride_metrics with a reference model and an expected-value queue.
module tb_ride_metrics;
    import ride_metrics_pkg::*;

    localparam int CIRC    = 2100;
    localparam int WIN     = 4;
    localparam int DEB     = 20;
    localparam int HS_CLKS = 200;
    localparam int MUL     = 118;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    longint tot_mm;
    int     mov, win_p, exp_speed, exp_max, exp_avg;

    ride_metrics_if bus();

    ride_metrics #(
        .CIRC_MM         (CIRC),
        .WINDOW_HALFSECS (WIN),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, want);
        end
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=%0d exp=none", obs);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic push_exp(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    function automatic int m_speed(input int p);
        longint mm;
        longint s;
        mm = longint'(p) * CIRC;
        if (mm > 65535) mm = 65535;
        s = (mm * MUL) >> 16;
        return (s > 99) ? 99 : int'(s);
    endfunction

    function automatic int m_dist();
        longint d;
        d = tot_mm / 100000;
        return (d > 9999) ? 9999 : int'(d);
    endfunction

    function automatic int m_avg();
        longint a;
        if (mov == 0) return 0;
        a = (tot_mm / 1000) * 72 / mov;
        return (a > 999) ? 999 : int'(a);
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_speed"}, bus.speed, 0);
        chk({tag, "_max"}, bus.max_speed, 0);
        chk({tag, "_dist"}, bus.distance, 0);
        chk({tag, "_avg"}, bus.avg_speed, 0);
    endtask

    // One half-second: mode 0 spreads n pulses evenly; modes 1/2 probe the lockout
    // (n is the number of revolutions that should be counted). Tick on the last clock.
    task automatic hs(input int n, input int mode);
        for (int c = 0; c < HS_CLKS; c++) begin
            bit hi;
            hi = 1'b0;
            if (mode == 0) begin
                for (int i = 0; i < n; i++) begin
                    int p;
                    p = 5 + i * (190 / n);
                    if (c >= p && c < p + 3) hi = 1'b1;
                end
            end else if (mode == 1) begin
                hi = (c >= 5 && c < 8) || (c >= 15 && c < 18) || (c >= 26 && c < 29);
            end else begin
                hi = (c >= 5 && c < 8) || (c >= 25 && c < 28);
            end
            bus.wheel_raw      = hi;
            bus.half_sec_pulse = (c == HS_CLKS - 1);
            cyc();
        end
        bus.wheel_raw      = 1'b0;
        bus.half_sec_pulse = 1'b0;
        win_p  += n;
        tot_mm += longint'(n) * CIRC;
        if (n > 0) mov++;
        chk("distance", bus.distance, m_dist());
    endtask

    // Called one clock after the closing tick; optionally clears the trip mid-divide.
    task automatic win_end(input bit clr);
        chk("speed_hold", bus.speed, exp_speed);
        exp_speed = m_speed(win_p);
        if (exp_speed > exp_max) exp_max = exp_speed;
        push_exp("win_speed", exp_speed);
        push_exp("win_max", exp_max);
        win_p = 0;
        cyc();
        pop_chk(bus.speed);
        pop_chk(bus.max_speed);
        if (!clr) begin
            repeat (27) cyc();
            chk("avg_hold", bus.avg_speed, exp_avg);
            exp_avg = m_avg();
            cyc();
            chk("avg_new", bus.avg_speed, exp_avg);
        end else begin
            repeat (8) cyc();
            bus.clear_trip = 1'b1;
            cyc();
            bus.clear_trip = 1'b0;
            tot_mm  = 0;
            mov     = 0;
            exp_max = 0;
            exp_avg = 0;
            chk("clr_dist", bus.distance, 0);
            chk("clr_max", bus.max_speed, 0);
            chk("clr_avg", bus.avg_speed, 0);
            chk("clr_speed_kept", bus.speed, exp_speed);
            repeat (30) cyc();
            chk("clr_no_writeback", bus.avg_speed, 0);
        end
    endtask

    initial begin
        bus.wheel_raw      = 1'b0;
        bus.half_sec_pulse = 1'b0;
        bus.clear_trip     = 1'b0;
        tot_mm = 0; mov = 0; win_p = 0; exp_speed = 0; exp_max = 0; exp_avg = 0;

        #23 reset = 1'b1;
        cyc();
        chk_zero("rst");

        // ride one window, then reset between clock edges
        repeat (4) hs(5, 0);
        win_end(1'b0);
        #3 reset = 1'b0;
        #1 chk_zero("rst_async");
        tot_mm = 0; mov = 0; win_p = 0; exp_speed = 0; exp_max = 0; exp_avg = 0;
        #3 reset = 1'b1;
        cyc();

        // no pulses after reset: everything stays 0
        repeat (4) hs(0, 0);
        win_end(1'b0);
        chk_zero("idle");

        // 10 pulses per window, four windows, moving every half-second
        repeat (4) begin
            hs(3, 0); hs(2, 0); hs(3, 0); hs(2, 0);
            win_end(1'b0);
        end

        // distance boundary at 48 revolutions, then 96; last window saturates win_mm and speed
        hs(7, 0); hs(1, 0); hs(8, 0); hs(8, 0);
        win_end(1'b0);
        repeat (4) hs(8, 0);
        win_end(1'b0);

        // clear during a divide, then a fresh 20-pulse window
        repeat (4) hs(5, 0);
        win_end(1'b1);
        repeat (4) hs(5, 0);
        win_end(1'b0);

        // lockout: 10 clocks apart dropped, DEB+1 later counted, exactly DEB later dropped
        hs(2, 1); hs(1, 2); hs(0, 0); hs(0, 0);
        win_end(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
